// File: rtl/irrigation_zone_scheduler.sv
// Round-robin irrigation scheduler. It grants one requesting zone at a time and runs a timed
// valve-open / pump / valve-close cycle. A tank interlock aborts the cycle and forces lockout.
module irrigation_zone_scheduler #(
    parameter int NUM_ZONES    = 4,
    parameter int CNT_W        = 8,
    parameter int SETTLE_TICKS = 2,
    parameter int WATER_TICKS  = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         enable,
    input  logic [NUM_ZONES-1:0]         zoneReq,
    input  logic                         tankLow,
    input  logic                         alarmIn,
    output logic [NUM_ZONES-1:0]         zoneValve,
    output logic                         pumpOn,
    output logic                         busy,
    output logic [$clog2(NUM_ZONES)-1:0] curZone,
    output logic                         zoneDone,
    output logic                         abortPulse,
    output logic                         lockout
);
    localparam int ZW = $clog2(NUM_ZONES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0] WATER_LAST  = CNT_W'(WATER_TICKS - 1);

    typedef enum logic [2:0] {IDLE, OPEN, WATER, CLOSE, LOCKOUT} stateT;

    stateT            state, nextState;
    logic [CNT_W-1:0] cnt;
    logic [ZW-1:0]    rrPtr, grantIdx, nextZone;
    logic [ZW:0]      probe;
    logic             grantValid, intlk, startGrant, abortNow, finishClose, aborted;

    assign intlk    = tankLow | alarmIn;
    assign busy     = (state != IDLE);
    assign nextZone = (curZone == ZW'(NUM_ZONES - 1)) ? '0 : curZone + 1'b1;

    // Walk downward so the last match written is the first requester at or above rrPtr.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        probe      = '0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            probe = {1'b0, rrPtr} + (ZW + 1)'(i);
            if (probe >= (ZW + 1)'(NUM_ZONES)) probe = probe - (ZW + 1)'(NUM_ZONES);
            if (zoneReq[probe[ZW-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = probe[ZW-1:0];
            end
        end
    end

    always_comb begin
        nextState   = state;
        startGrant  = 1'b0;
        abortNow    = 1'b0;
        finishClose = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !intlk && grantValid) begin
                    nextState  = OPEN;
                    startGrant = 1'b1;
                end
            end
            OPEN: begin
                if (intlk) begin
                    nextState = CLOSE;
                    abortNow  = 1'b1;
                end else if (tick && cnt == SETTLE_LAST) begin
                    nextState = WATER;
                end
            end
            WATER: begin
                // Interlock takes priority over the final water tick.
                if (intlk) begin
                    nextState = CLOSE;
                    abortNow  = 1'b1;
                end else if (tick && cnt == WATER_LAST) begin
                    nextState = CLOSE;
                end
            end
            CLOSE: begin
                if (tick && cnt == SETTLE_LAST) begin
                    finishClose = 1'b1;
                    nextState   = aborted ? LOCKOUT : IDLE;
                end
            end
            LOCKOUT: begin
                if (tick && !intlk) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rrPtr      <= '0;
            curZone    <= '0;
            zoneValve  <= '0;
            pumpOn     <= 1'b0;
            zoneDone   <= 1'b0;
            abortPulse <= 1'b0;
            lockout    <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= nextState;
            zoneDone   <= 1'b0;
            abortPulse <= 1'b0;
            pumpOn     <= (nextState == WATER);
            lockout    <= (nextState == LOCKOUT) || (state == IDLE && nextState == IDLE && intlk);
            if (nextState != state) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
            if (startGrant) begin
                curZone   <= grantIdx;
                zoneValve <= NUM_ZONES'(1) << grantIdx;
                aborted   <= 1'b0;
            end
            if (abortNow) begin
                abortPulse <= 1'b1;
                aborted    <= 1'b1;
            end
            // An aborted zone keeps the pointer so it is served first after recovery.
            if (finishClose) begin
                zoneValve <= '0;
                if (aborted) begin
                    rrPtr <= curZone;
                end else begin
                    rrPtr    <= nextZone;
                    zoneDone <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Scoreboard bench for irrigation_zone_scheduler: the stimulus queues expected grant, done and
// abort events, and a monitor pops them and compares them as the DUT produces them.
module tb_irrigation_zone_scheduler;
    localparam int NZ       = 4;
    localparam int SETTLE   = 2;
    localparam int WATER    = 10;
    localparam int EV_GRANT = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;
    localparam int W_VALVE_ON  = 0;
    localparam int W_PUMP_ON   = 1;
    localparam int W_LOCKOUT   = 2;
    localparam int W_DONE      = 3;
    localparam int W_VALVE_OFF = 4;

    logic          clock, reset, tick, enable, tankLow, alarmIn;
    logic [NZ-1:0] zoneReq, zoneValve;
    logic          pumpOn, busy, zoneDone, abortPulse, lockout;
    logic [1:0]    curZone;

    typedef struct {
        int kind;
        int zone;
        int openC;
        int pumpC;
        int closeC;
    } evT;

    evT expQ[$];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int tickDiv    = 1;
    int tickPhase  = 0;

    irrigation_zone_scheduler #(
        .NUM_ZONES(NZ), .CNT_W(8), .SETTLE_TICKS(SETTLE), .WATER_TICKS(WATER)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .enable(enable), .zoneReq(zoneReq),
        .tankLow(tankLow), .alarmIn(alarmIn), .zoneValve(zoneValve), .pumpOn(pumpOn),
        .busy(busy), .curZone(curZone), .zoneDone(zoneDone), .abortPulse(abortPulse),
        .lockout(lockout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever @(posedge clock) cyc++;

    // The tick strobe is high on one clock in every tickDiv.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clock);
            tickPhase = (tickPhase + 1) % tickDiv;
            tick = (tickPhase == 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [NZ-1:0] req, input logic tl, input logic al, input logic en);
        zoneReq = req;
        tankLow = tl;
        alarmIn = al;
        enable  = en;
    endtask

    task automatic expectEvent(input int kind, input int zone, input int o, input int p, input int c);
        evT e;
        e.kind   = kind;
        e.zone   = zone;
        e.openC  = o;
        e.pumpC  = p;
        e.closeC = c;
        expQ.push_back(e);
    endtask

    task automatic popExpected(input int kind, output evT e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedEvent: actual=kind%0d required=none (cycle %0d)", kind, cyc);
        end else begin
            e = expQ.pop_front();
            checkOutput("eventKind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    task automatic waitUntil(input int sel, input int budget, input string name);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clock);
            case (sel)
                W_VALVE_ON:  hit = (zoneValve != '0);
                W_PUMP_ON:   hit = pumpOn;
                W_LOCKOUT:   hit = lockout;
                W_DONE:      hit = zoneDone;
                W_VALVE_OFF: hit = (zoneValve == '0);
                default:     hit = 1'b1;
            endcase
            n++;
        end
        if (!hit) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL timeout %s: actual=%0d cycles required=<%0d", name, n, budget);
        end
    endtask

    // Monitor: invariants every cycle, plus event-by-event comparison against the queue.
    initial begin
        logic [NZ-1:0] prevValve;
        logic          prevPump;
        int            grantCyc, pumpRise, pumpFall;
        evT            e;
        bit            ok;
        prevValve = '0;
        prevPump  = 1'b0;
        grantCyc  = 0;
        pumpRise  = 0;
        pumpFall  = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                checkOutput("valveOneHot0", int'($onehot0(zoneValve)), 1);
                if (pumpOn) checkOutput("pumpNeedsValve", int'($onehot(zoneValve)), 1);
                if (pumpOn && !prevPump) pumpRise = cyc;
                if (!pumpOn && prevPump) pumpFall = cyc;
                if (zoneValve != '0 && prevValve == '0) begin
                    grantCyc = cyc;
                    popExpected(EV_GRANT, e, ok);
                    if (ok) begin
                        checkOutput("grantValve", int'(zoneValve), 1 << e.zone);
                        checkOutput("grantCurZone", int'(curZone), e.zone);
                    end
                end
                if (abortPulse) begin
                    popExpected(EV_ABORT, e, ok);
                    if (ok) checkOutput("abortZone", int'(curZone), e.zone);
                end
                if (zoneDone) begin
                    popExpected(EV_DONE, e, ok);
                    if (ok) begin
                        checkOutput("doneZone", int'(curZone), e.zone);
                        checkOutput("openCycles", pumpRise - grantCyc, e.openC);
                        checkOutput("pumpCycles", pumpFall - pumpRise, e.pumpC);
                        checkOutput("closeCycles", cyc - pumpFall, e.closeC);
                    end
                end
            end
            prevValve = zoneValve;
            prevPump  = pumpOn;
        end
    end

    initial begin
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clock);
            checkOutput("rstValve", int'(zoneValve), 0);
            checkOutput("rstPumpBusy", int'({pumpOn, busy}), 0);
            checkOutput("rstPulsesLock", int'({zoneDone, abortPulse, lockout}), 0);
            checkOutput("rstCurZone", int'(curZone), 0);
        end

        $display("[TB] test 1: single zone full cycle");
        reset = 1'b0;
        expectEvent(EV_GRANT, 2, 0, 0, 0);
        expectEvent(EV_DONE, 2, SETTLE, WATER, SETTLE);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("t1GrantNextEdge", int'(zoneValve), 4);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        waitUntil(W_DONE, 40, "t1Done");
        enable = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] test 2: round robin between zones 0 and 3");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("t2EnableLowBlocks", int'({busy, zoneValve}), 0);
        expectEvent(EV_GRANT, 0, 0, 0, 0);
        expectEvent(EV_DONE, 0, SETTLE, WATER, SETTLE);
        expectEvent(EV_GRANT, 3, 0, 0, 0);
        expectEvent(EV_DONE, 3, SETTLE, WATER, SETTLE);
        expectEvent(EV_GRANT, 0, 0, 0, 0);
        expectEvent(EV_DONE, 0, SETTLE, WATER, SETTLE);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            waitUntil(W_VALVE_ON, 20, "t2Grant");
            if (k == 2) zoneReq = 4'b0000;
            waitUntil(W_VALVE_OFF, 40, "t2Close");
        end
        repeat (3) @(negedge clock);

        $display("[TB] test 3: interlock abort during WATER");
        expectEvent(EV_GRANT, 1, 0, 0, 0);
        expectEvent(EV_ABORT, 1, 0, 0, 0);
        expectEvent(EV_GRANT, 1, 0, 0, 0);
        expectEvent(EV_DONE, 1, SETTLE, WATER, SETTLE);
        applyStimulus(4'b0110, 1'b0, 1'b0, 1'b1);
        waitUntil(W_PUMP_ON, 20, "t3Pump");
        repeat (4) @(negedge clock);
        tankLow = 1'b1;
        @(negedge clock);
        checkOutput("t3AbortPump", int'(pumpOn), 0);
        checkOutput("t3AbortPulse", int'(abortPulse), 1);
        waitUntil(W_LOCKOUT, 20, "t3Lockout");
        checkOutput("t3LockValve", int'({zoneValve, pumpOn}), 0);
        repeat (3) @(negedge clock);
        checkOutput("t3LockHeld", int'({lockout, busy}), 3);
        tankLow = 1'b0;
        waitUntil(W_VALVE_ON, 20, "t3Regrant");
        zoneReq = 4'b0000;
        waitUntil(W_DONE, 40, "t3Done");
        repeat (2) @(negedge clock);

        $display("[TB] test 4: interlock blocks grant in IDLE");
        applyStimulus(4'b0010, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        checkOutput("t4AlarmLock", int'({lockout, busy}), 2);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clock);
        checkOutput("t4TankLowLock", int'(lockout), 1);
        checkOutput("t4NoValve", int'(zoneValve), 0);
        expectEvent(EV_GRANT, 1, 0, 0, 0);
        expectEvent(EV_DONE, 1, SETTLE, WATER, SETTLE);
        tankLow = 1'b0;
        @(negedge clock);
        checkOutput("t4ReleaseGrant", int'(zoneValve), 2);
        zoneReq = 4'b0000;
        waitUntil(W_DONE, 40, "t4Done");
        repeat (2) @(negedge clock);

        $display("[TB] test 5: tick every 4th clock");
        tickDiv = 4;
        expectEvent(EV_GRANT, 0, 0, 0, 0);
        expectEvent(EV_DONE, 0, 4 * SETTLE, 4 * WATER, 4 * SETTLE);
        do begin
            @(negedge clock);
            #1;
        end while (!tick);
        zoneReq = 4'b0001;
        waitUntil(W_VALVE_ON, 5, "t5Grant");
        zoneReq = 4'b0000;
        waitUntil(W_DONE, 100, "t5Done");
        tickDiv = 1;
        repeat (3) @(negedge clock);

        $display("[TB] test 6: reset during WATER");
        expectEvent(EV_GRANT, 3, 0, 0, 0);
        zoneReq = 4'b1000;
        waitUntil(W_PUMP_ON, 20, "t6Pump");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t6RstValve", int'(zoneValve), 0);
        checkOutput("t6RstPumpBusy", int'({pumpOn, busy}), 0);
        checkOutput("t6RstPulses", int'({zoneDone, abortPulse}), 0);
        expectEvent(EV_GRANT, 0, 0, 0, 0);
        expectEvent(EV_DONE, 0, SETTLE, WATER, SETTLE);
        reset = 1'b0;
        zoneReq = 4'b1001;
        waitUntil(W_VALVE_ON, 5, "t6Grant");
        zoneReq = 4'b0000;
        waitUntil(W_DONE, 40, "t6Done");
        repeat (5) @(negedge clock);

        checkOutput("queueDrained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
